// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the MIPS elastic pipeline chain.
//   PIPE_DATA_WIDTH : default packet width carried between stages
//   PIPE_STAGES     : default chain depth (ID, EX, MEM, WB)
//   ST_*            : stage indices used by hazard and flush logic
//   occ_width()     : width of an occupancy counter for a given depth
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

   localparam int PIPE_DATA_WIDTH = 32;
   localparam int PIPE_STAGES     = 4;

   localparam int ST_ID  = 0;
   localparam int ST_EX  = 1;
   localparam int ST_MEM = 2;
   localparam int ST_WB  = 3;

   function automatic int occ_width(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/mips_pipe_chain_if.sv
// -----------------------------------------------------------------------------
// mips_pipe_chain_if
// Bundles the upstream/downstream handshake, per-stage stall/flush controls
// and the stage taps of the pipeline chain.
//   master : the processor side (drives in_*, stall, flush, out_ready)
//   slave  : the chain itself (drives in_ready, out_*, stage taps, occupancy)
// -----------------------------------------------------------------------------
interface mips_pipe_chain_if
   import mips_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
   parameter int STAGES     = PIPE_STAGES
);

   localparam int OCC_W = occ_width(STAGES);

   logic                         in_valid;
   logic                         in_ready;
   logic [DATA_WIDTH-1:0]        in_data;
   logic [STAGES-1:0]            stall;
   logic [STAGES-1:0]            flush;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_WIDTH-1:0]        out_data;
   logic [STAGES-1:0]            stage_valid;
   logic [STAGES*DATA_WIDTH-1:0] stage_data;
   logic [OCC_W-1:0]             occupancy;

   modport master (
      output in_valid, in_data, stall, flush, out_ready,
      input  in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, stall, flush, out_ready,
      output in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
   );

endinterface

// File: rtl/mips_pipe_stage.sv
// -----------------------------------------------------------------------------
// mips_pipe_stage
// One valid+data register of the elastic chain.
//   clk, reset    : clock, asynchronous active-low reset
//   load_i        : stage takes new content this edge
//   bubble_i      : when loading, take an empty slot instead of the source
//   flush_i       : kill whatever the stage holds after this edge
//   src_valid_i   : valid bit of the source (input or previous stage)
//   src_data_i    : payload of the source
//   valid_o/data_o: registered stage contents
// -----------------------------------------------------------------------------
module mips_pipe_stage
   import mips_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_WIDTH
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  bubble_i,
   input  logic                  flush_i,
   input  logic                  src_valid_i,
   input  logic [DATA_WIDTH-1:0] src_data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = bubble_i ? 1'b0 : src_valid_i;
         // A bubble leaves the old payload in place; it is don't-care anyway.
         if (!bubble_i) data_d = src_data_i;
      end
      // Flush wins over hold and over an entry arriving on the same edge.
      if (flush_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/mips_pipe_chain.sv
// -----------------------------------------------------------------------------
// mips_pipe_chain
// Elastic chain of STAGES pipeline registers with per-stage stall (hold plus
// bubble into the next stage) and flush (kill), valid/ready at both ends.
//   clk, reset : clock, asynchronous active-low reset
//   pipe       : slave side of mips_pipe_chain_if
//                in_valid/in_ready/in_data    upstream handshake into stage 0
//                out_valid/out_ready/out_data last stage handshake
//                stall/flush                  per-stage controls
//                stage_valid/stage_data       taps for hazard/forwarding logic
//                occupancy                    number of valid stages
// -----------------------------------------------------------------------------
module mips_pipe_chain
   import mips_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
   parameter int STAGES     = PIPE_STAGES
)
(
   input  logic             clk,
   input  logic             reset,
   mips_pipe_chain_if.slave pipe
);

   localparam int OCC_W = occ_width(STAGES);

   logic [STAGES-1:0]     valid;
   logic [STAGES-1:0]     move;
   logic [STAGES-1:0]     xfer;
   logic [STAGES-1:0]     src_valid;
   logic [DATA_WIDTH-1:0] data     [STAGES];
   logic [DATA_WIDTH-1:0] src_data [STAGES];
   logic [OCC_W-1:0]      occ;

   // Ready ripple from the output back to stage 0: a stage moves when it is
   // not stalled and is either empty (bubble squeeze) or being drained.
   // This path is purely combinational and STAGES deep by design.
   always_comb begin : ripple
      logic acc_nxt;
      move    = '0;
      acc_nxt = pipe.out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         move[i] = !pipe.stall[i] && (!valid[i] || acc_nxt);
         acc_nxt = move[i];
      end
   end

   // Source selection. A stalled predecessor does not transfer, so the
   // loading stage receives a bubble rather than a duplicate.
   always_comb begin
      xfer        = '0;
      src_valid   = '0;
      src_data    = '{default: '0};
      xfer[0]     = pipe.in_valid;
      src_valid[0] = pipe.in_valid;
      src_data[0] = pipe.in_data;
      for (int i = 1; i < STAGES; i++) begin
         xfer[i]      = !pipe.stall[i-1];
         src_valid[i] = valid[i-1];
         src_data[i]  = data[i-1];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      mips_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
         .clk         (clk),
         .reset       (reset),
         .load_i      (move[g]),
         .bubble_i    (!xfer[g]),
         .flush_i     (pipe.flush[g]),
         .src_valid_i (src_valid[g]),
         .src_data_i  (src_data[g]),
         .valid_o     (valid[g]),
         .data_o      (data[g])
      );
      assign pipe.stage_data[g*DATA_WIDTH +: DATA_WIDTH] = data[g];
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ = occ + OCC_W'(valid[i]);
      end
   end

   assign pipe.in_ready    = move[0];
   assign pipe.out_valid   = valid[STAGES-1];
   assign pipe.out_data    = data[STAGES-1];
   assign pipe.stage_valid = valid;
   assign pipe.occupancy   = occ;

endmodule

// File: tb/tb_mips_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_mips_pipe_chain
// Directed stimulus for mips_pipe_chain (4 stages x 32 bits). Expected
// retirements are queued by the stimulus; a negedge monitor pops and compares
// on every out_valid && out_ready. Control/status is checked inline.
// -----------------------------------------------------------------------------
module tb_mips_pipe_chain;
   import mips_pipe_pkg::*;

   localparam int DW = 32;
   localparam int S  = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mips_pipe_chain_if #(.DATA_WIDTH(DW), .STAGES(S)) ifc ();

   mips_pipe_chain #(.DATA_WIDTH(DW), .STAGES(S)) dut (
      .clk   (clk),
      .reset (reset),
      .pipe  (ifc.slave)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] e_mon;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Retirement monitor
   always @(negedge clk) begin
      if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h, required no retirement", ifc.out_data);
         end else begin
            e_mon = exp_q.pop_front();
            chk("out_data", {32'h0, ifc.out_data}, {32'h0, e_mon});
         end
      end
   end

   initial begin
      // ---------------- reset ----------------
      reset         = 1'b0;
      ifc.in_valid  = 1'b1;
      ifc.in_data   = 32'hDEAD_BEEF;
      ifc.stall     = '0;
      ifc.flush     = '0;
      ifc.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid",   64'(ifc.out_valid),   64'd0);
      chk("rst_occupancy",   64'(ifc.occupancy),   64'd0);
      chk("rst_stage_valid", 64'(ifc.stage_valid), 64'd0);
      chk("rst_in_ready",    64'(ifc.in_ready),    64'd1);
      exp_q.push_back(32'hDEAD_BEEF);
      step();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 0) ifc.in_valid = 1'b0;
         @(negedge clk);
         chk("latency_out_valid", 64'(ifc.out_valid), 64'(c == 3));
      end
      step();
      step();

      // ---------------- streaming 1..10 ----------------
      for (int v = 1; v <= 10; v++) exp_q.push_back(DW'(v));
      for (int i = 1; i <= 14; i++) begin
         if (i <= 10) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = DW'(i);
         end else begin
            ifc.in_valid = 1'b0;
         end
         @(negedge clk);
         if (i <= 10)           chk("stream_in_ready",  64'(ifc.in_ready),  64'd1);
         if (i >= 5)            chk("stream_out_valid", 64'(ifc.out_valid), 64'd1);
         if (i >= 5 && i <= 11) chk("stream_occupancy", 64'(ifc.occupancy), 64'd4);
         step();
      end

      // ---------------- back-pressure ----------------
      for (int v = 1; v <= 6; v++) exp_q.push_back(DW'(v));
      for (int c = 0; c <= 12; c++) begin
         ifc.out_ready = (c >= 6);
         if (c <= 6) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = (c < 4) ? DW'(c + 1) : DW'(5);
         end else if (c == 7) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = DW'(6);
         end else begin
            ifc.in_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 6)            chk("bp_in_ready",  64'(ifc.in_ready),  64'(c < 4));
         if (c == 4 || c == 5) chk("bp_occupancy", 64'(ifc.occupancy), 64'd4);
         step();
      end
      ifc.out_ready = 1'b1;

      // ---------------- stall bubble ----------------
      exp_q.push_back(32'hAAAA_000A);
      exp_q.push_back(32'hBBBB_000B);
      exp_q.push_back(32'hCCCC_000C);
      for (int c = 0; c <= 8; c++) begin
         ifc.stall = '0;
         case (c)
            0: begin ifc.in_valid = 1'b1; ifc.in_data = 32'hAAAA_000A; end
            1: begin ifc.in_valid = 1'b1; ifc.in_data = 32'hBBBB_000B; end
            2: begin ifc.in_valid = 1'b1; ifc.in_data = 32'hCCCC_000C; end
            3: begin ifc.in_valid = 1'b0; ifc.stall = 4'b0010; end
            default: ifc.in_valid = 1'b0;
         endcase
         @(negedge clk);
         if (c == 3) chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
         if (c == 4) begin
            chk("stall_stage_valid", 64'(ifc.stage_valid), 64'b1011);
            chk("stall_hold_B", 64'(ifc.stage_data[ST_EX*DW +: DW]), 64'h0000_0000_BBBB_000B);
            chk("stall_A_last", 64'(ifc.stage_data[ST_WB*DW +: DW]), 64'h0000_0000_AAAA_000A);
         end
         if (c == 5)           chk("stall_bubble_out", 64'(ifc.out_valid), 64'd0);
         if (c == 6 || c == 7) chk("stall_out_valid",  64'(ifc.out_valid), 64'd1);
         step();
      end

      // ---------------- flush ----------------
      exp_q.push_back(DW'(9));
      for (int c = 0; c <= 7; c++) begin
         ifc.stall = '0;
         ifc.flush = '0;
         case (c)
            0: begin ifc.in_valid = 1'b1; ifc.in_data = DW'(9); end
            1: begin ifc.in_valid = 1'b1; ifc.in_data = DW'(8); end
            2: begin ifc.in_valid = 1'b1; ifc.in_data = DW'(7); end
            3: begin ifc.in_valid = 1'b0; ifc.stall = 4'b0011; ifc.flush = 4'b0011; end
            default: ifc.in_valid = 1'b0;
         endcase
         @(negedge clk);
         if (c == 3) chk("flush_occ_before", 64'(ifc.occupancy), 64'd3);
         if (c == 4) begin
            chk("flush_occ_after",    64'(ifc.occupancy),   64'd1);
            chk("flush_stage_valid",  64'(ifc.stage_valid), 64'b1000);
         end
         if (c >= 5) chk("flush_no_retire", 64'(ifc.out_valid), 64'd0);
         step();
      end

      // ---------------- flush vs stall on stage 0 ----------------
      for (int c = 0; c <= 5; c++) begin
         ifc.stall = '0;
         ifc.flush = '0;
         case (c)
            0: begin ifc.in_valid = 1'b1; ifc.in_data = 32'h55; end
            1: begin ifc.in_valid = 1'b1; ifc.in_data = 32'h66;
                     ifc.stall = 4'b0001; ifc.flush = 4'b0001; end
            default: ifc.in_valid = 1'b0;
         endcase
         @(negedge clk);
         if (c == 1) begin
            chk("fs_in_ready",     64'(ifc.in_ready),    64'd0);
            chk("fs_valid_before", 64'(ifc.stage_valid), 64'b0001);
         end
         if (c == 2) begin
            chk("fs_stage_valid", 64'(ifc.stage_valid), 64'b0000);
            chk("fs_occupancy",   64'(ifc.occupancy),   64'd0);
         end
         if (c >= 3) chk("fs_no_retire", 64'(ifc.out_valid), 64'd0);
         step();
      end

      // ---------------- reset mid-operation ----------------
      ifc.in_valid = 1'b1;
      ifc.in_data  = 32'h1111;
      step();
      ifc.in_data  = 32'h2222;
      step();
      ifc.in_valid = 1'b0;
      @(negedge clk);
      chk("mrst_occ_before", 64'(ifc.occupancy), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("mrst_occupancy",   64'(ifc.occupancy),   64'd0);
      chk("mrst_stage_valid", 64'(ifc.stage_valid), 64'd0);
      chk("mrst_in_ready",    64'(ifc.in_ready),    64'd1);
      step();
      reset = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("mrst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("leftover_expected", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_pipe_chain.md
# mips_pipe_chain

Parametrised elastic pipeline-register chain that replaces the fixed, always-advancing stage registers between the MIPS datapath stages. It holds `STAGES` back-to-back registers of `DATA_WIDTH` bits, each with its own valid bit, and adds per-stage stall (hold plus bubble insertion) and per-stage flush (kill), with a valid/ready handshake at both ends. The processor top instantiates one chain for the IF→WB packet; hazard and branch logic drive `stall`/`flush`, and forwarding logic reads the stage taps.

## Interface
- `DATA_WIDTH`, 32: payload bits per stage (instruction, PC+4, control, ALU result, etc., packed by the top).
- `STAGES`, 4: number of register stages; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a packet on `in_data`.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `in_data`  in  DATA_WIDTH  packet entering stage 0.
- `stall`  in  STAGES  bit i holds stage i this cycle.
- `flush`  in  STAGES  bit i kills whatever stage i holds after this edge.
- `out_valid`  out  1  equals `valid[STAGES-1]`.
- `out_ready`  in  1  downstream consumes the last stage.
- `out_data`  out  DATA_WIDTH  equals `data[STAGES-1]`.
- `stage_valid`  out  STAGES  per-stage valid bits, for hazard logic.
- `stage_data`  out  STAGES*DATA_WIDTH  flattened stage contents; stage i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `occupancy`  out  $clog2(STAGES+1)  popcount of `stage_valid`.

## Operation
- Stage i signals, all combinational:
  - `acc_i`: downstream accepts stage i. `acc_{S-1} = out_ready`; for i < S-1, `acc_i = move_{i+1}`.
  - `move_i`: stage i loads new content. `move_i = !stall[i] && (!valid_i || acc_i)`.
- Source into stage i:
  - For i = 0, the source is the input, and `xfer_0 = in_valid`.
  - For i > 0, the source is stage i-1, and `xfer_i = !stall[i-1]`.
- When `move_i`:
  - `valid_i <= xfer_i ? src_valid : 0`.
  - `data_i <= src_data` only when `xfer_i`; otherwise data is retained.
  - A stalled stage i-1 therefore leaves a bubble in stage i and is never duplicated.
- When `!move_i`, stage i holds its contents.
- Flush has priority over everything: `flush[i]` forces `valid_i` to 0 after the edge, including an entry arriving that edge.
- `in_ready = move_0`. Input is consumed iff `in_valid && in_ready && !flush[0]`.
- `out_valid && out_ready` retires the last stage.
- Stall applies even to an empty stage: nothing enters it.
- Data in invalid stages is don't-care. Benches must not check it.

## Timing
- Reset (async assert, sync release): all valid bits = 0, all data = 0. Consequently `out_valid` = 0, `occupancy` = 0, and `in_ready` = `!stall[0]`.
- Latency: a packet accepted at edge k is visible with `out_valid` = 1 in the cycle after edge k+STAGES-1, i.e. STAGES cycles, provided there are no stalls and `out_ready` = 1.
- Throughput: 1 packet per cycle.
- Bubble squeeze: an empty stage always loads, even when downstream is blocked.
- Combinational paths: `in_ready` depends on `out_ready` and `stall` through a ripple chain that is STAGES deep. No register sits in that path. This is accepted by design.
- Reset asserted mid-operation clears every stage immediately, with no partial retirement.
- Simultaneous events:
  - `stall[i]` together with `flush[i]`: the stage is cleared.
  - Flush of stage i does not affect stage i+1 loading from stage i at the same edge; the packet moves and survives unless `flush[i+1]` is also set.

## Structure
- Shared package `mips_pipe_pkg`:
  - `PIPE_DATA_WIDTH` = 32.
  - Stage index constants `ST_ID`=0, `ST_EX`=1, `ST_MEM`=2, `ST_WB`=3, used by the top's hazard and flush logic.
- One natural sub-module, `mips_pipe_stage`:
  - Holds a single valid+data register with load, bubble and flush inputs.
  - Instantiated STAGES times by a generate loop.
  - The chain module keeps the move/acc ripple and occupancy.

## Test plan
- **Reset:** hold `reset`=0, drive `in_valid`=1 with `in_data`=32'hDEAD_BEEF. Require `out_valid`=0 and `occupancy`=0. After release with `stall`=0, `out_data`=32'hDEAD_BEEF appears exactly 4 cycles after acceptance.
- **Streaming:** feed 1,2,3,…,10 on consecutive cycles with `out_ready`=1. Require outputs 1..10 on consecutive cycles, no gaps, and `occupancy` steady at 4.
- **Back-pressure:** `out_ready`=0 for 6 cycles while feeding 1..6. Require `in_ready` to fall after 4 accepts and `occupancy`=4. On release, 1..4 drain in order, followed by 5 and 6.
- **Stall bubble:** `stall[1]`=1 for 1 cycle with packets A,B,C in flight. Require stage 2 to receive a bubble, stage 1 to hold B, A to retire normally, and the out stream to read A,–,B,C.
- **Flush:** packets 7,8,9 in stages 0..2 and `flush`=4'b0011 for one edge. Require only 9 to retire; 7 and 8 never appear, and `occupancy` drops by 2.
- **Flush vs stall:** `stall[0]`=1 and `flush[0]`=1 on the same edge. Require `stage_valid[0]`=0 and `in_ready`=0 that cycle.
